// File: rtl/comparador_sequencial_if.sv
// Request/result bundle for the sequential magnitude comparator.
// The master drives operands and start; the slave returns status and the G/L/E verdict.
interface comparador_sequencial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             G;
    logic             L;
    logic             E;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, G, L, E
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, G, L, E
    );
endinterface

// File: rtl/comparador_sequencial.sv
// Multi-cycle magnitude comparator: scans two latched operands MSB-first, STEP bits
// per clock, and stops at the first differing chunk with a one-cycle done pulse.
module comparador_sequencial #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    comparador_sequencial_if.slave bus
);
    localparam int N     = WIDTH / STEP;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((WIDTH < 2) || ((WIDTH % STEP) != 0)) begin : g_bad_params
        $error("comparador_sequencial: WIDTH must be >= 2 and a multiple of STEP");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_g;
    logic             w_g_nxt;
    logic             r_l;
    logic             w_l_nxt;
    logic             r_e;
    logic             w_e_nxt;
    logic             w_load;
    logic             w_shift;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_ofs;
    logic [WIDTH-1:0] w_b_ofs;
    logic [STEP-1:0]  w_chunk_a;
    logic [STEP-1:0]  w_chunk_b;

    // Signed mode folds into the latch: flipping the MSB maps two's-complement
    // onto offset-binary, so every later chunk compare is plain unsigned.
    assign w_a_ofs   = bus.A ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
    assign w_b_ofs   = bus.B ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
    assign w_chunk_a = r_a[WIDTH-1 -: STEP];
    assign w_chunk_b = r_b[WIDTH-1 -: STEP];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_g_nxt     = r_g;
        w_l_nxt     = r_l;
        w_e_nxt     = r_e;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_g_nxt     = 1'b0;
                    w_l_nxt     = 1'b0;
                    w_e_nxt     = 1'b0;
                    w_load      = 1'b1;
                end
            end
            SCAN: begin
                if (w_chunk_a != w_chunk_b) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_g_nxt     = (w_chunk_a > w_chunk_b);
                    w_l_nxt     = (w_chunk_a < w_chunk_b);
                    w_e_nxt     = 1'b0;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_g_nxt     = 1'b0;
                    w_l_nxt     = 1'b0;
                    w_e_nxt     = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_shift     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_g     <= w_g_nxt;
            r_l     <= w_l_nxt;
            r_e     <= w_e_nxt;
        end
    end

    // Operands shift left each scan step so the chunk under test is always at the top.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_a <= w_a_ofs;
            r_b <= w_b_ofs;
        end else if (w_shift) begin
            r_a <= r_a << STEP;
            r_b <= r_b << STEP;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.G    = r_g;
    assign bus.L    = r_l;
    assign bus.E    = r_e;
endmodule

// File: doc/comparador_sequencial.md
# comparador_sequencial

Parametrised multi-cycle magnitude comparator: the sequential successor to the combinational 8-bit G/E/L comparator. It latches two WIDTH-bit operands on a start handshake and scans them MSB-first, STEP bits per clock, in unsigned or two's-complement mode. It terminates early on the first differing chunk and reports G/L/E with a one-cycle done pulse. It serves datapaths that trade comparison latency for area on wide operands.

## Interface
- WIDTH, 8, operand width in bits; ≥ 2.
- STEP, 1, bits examined per cycle; must divide WIDTH (elaboration-time error otherwise).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on the rising edge, accepted only while idle.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement; latched on accept.
- A  input  WIDTH  operand A; latched on accept.
- B  input  WIDTH  operand B; latched on accept.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; G/L/E are valid from this cycle onward.
- G  output  1  A > B.
- L  output  1  A < B.
- E  output  1  A == B.

## Operation
- Chunks: N = WIDTH/STEP. Chunk 0 is bits [WIDTH-1 : WIDTH-STEP]; chunk N-1 is bits [STEP-1 : 0].
- Signed mode: the MSB of both latched operands is inverted (offset-binary), after which every chunk is compared unsigned. Unsigned mode uses the operands unmodified.
- FSM states are IDLE and SCAN.
- IDLE + start=1 → SCAN:
  - latch A, B, signed_mode;
  - chunk index ← 0;
  - busy ← 1;
  - G/L/E ← 0.
- IDLE + start=0: hold state. Outputs keep their last values.
- SCAN, current chunk differs (a ≠ b):
  - G ← (a > b), L ← (a < b), E ← 0;
  - done ← 1, busy ← 0;
  - → IDLE.
- SCAN, chunk equal and index = N-1:
  - E ← 1, G ← L ← 0;
  - done ← 1, busy ← 0;
  - → IDLE.
- SCAN, chunk equal and index < N-1: index ← index+1. Stay in SCAN.
- start while busy is ignored and does not queue. Input changes while busy have no effect.
- start in the cycle where done=1 is accepted (the FSM is already IDLE). done falls and busy rises on that edge, and G/L/E clear.
- Exactly one of G/L/E is 1 from done until the next accepted start. All three are 0 while busy, and all three are 0 after reset until the first completion.
- The index counter is ceil(log2(N)) bits, with a minimum of 1, and never wraps: the exit at N-1 is mandatory.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, index=0, busy=0, done=0, G=0, L=0, E=0. Latched operands are don't-care.
- Reset during SCAN aborts immediately. No done is produced, and after release the block waits for a new start.
- Accept edge = T0. Let k = position of the first differing chunk + 1, or N if the operands are equal.
- done and the valid result appear at edge T0+k (latency 1..N cycles). busy is high for exactly k cycles (edges T0..T0+k).
- done is high for exactly one cycle, after edge T0+k.
- Throughput: back-to-back operations are possible with zero idle cycles between the done cycle and the next start.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, STEP=1, unsigned; A=0x40, B=0x40, start for one cycle → busy high 8 cycles; done after 8 edges; E=1, G=L=0.
- WIDTH=8, STEP=1, unsigned; A=0x41, B=0x40 → done after 8 edges, G=1. Then A=0x40, B=0x41 issued back-to-back in the done cycle → done 8 edges later, L=1.
- WIDTH=8, STEP=1, early exit; A=0x80, B=0x7F unsigned → done after 1 edge, G=1. Same operands signed (-128 vs 127) → done after 1 edge, L=1.
- WIDTH=16, STEP=4, signed; A=0xFFFE (-2), B=0xFFFF (-1) → done after 4 edges, L=1. Then A=0x1234, B=0x1234 → done after 4 edges, E=1.
- Start pulsed again mid-SCAN with different operands → ignored; result and latency match the original operands only.
- Assert rst_n=0 at the 3rd scan cycle of an 8-cycle compare → busy, done, G, L, E all 0 immediately. After release with start=0, no done for 20 cycles. A fresh start then completes normally.
